// File: rtl/lzc_normalizer_if.sv
// Stream bundle for the normaliser: upstream beat from the LZC, downstream normalised beat.
// The DUT takes the slave modport; the producer/consumer side takes master.
interface lzc_normalizer_if #(
    parameter int WIDTH = 16,
    parameter int COUNT = $clog2(WIDTH),
    parameter int EXP_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [COUNT-1:0] in_lz;
    logic             in_nz;
    logic [EXP_W-1:0] in_exp;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_mant;
    logic [EXP_W-1:0] out_exp;
    logic             out_zero;
    logic             out_uflow;
    logic [15:0]      uflow_cnt;

    modport master (
        output in_valid, in_data, in_lz, in_nz, in_exp, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow, uflow_cnt
    );

    modport slave (
        input  in_valid, in_data, in_lz, in_nz, in_exp, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow, uflow_cnt
    );
endinterface

// File: rtl/lzc_normalizer.sv
// Two-stage normaliser: stage 1 captures operand + LZC result, stage 2 shifts the
// mantissa up, lowers the exponent and clamps to a denormal when the exponent runs out.
module lzc_normalizer #(
    parameter int WIDTH = 16,
    parameter int COUNT = $clog2(WIDTH),
    parameter int EXP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    lzc_normalizer_if.slave   bus
);

    logic             r_s1_v;
    logic [WIDTH-1:0] r_s1_data;
    logic [COUNT-1:0] r_s1_lz;
    logic             r_s1_nz;
    logic [EXP_W-1:0] r_s1_exp;

    logic             r_s2_v;
    logic [WIDTH-1:0] r_mant;
    logic [EXP_W-1:0] r_exp;
    logic             r_zero;
    logic             r_uflow;
    logic [15:0]      r_uflow_cnt;

    logic             w_adv2;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_pop;
    logic             w_zero;
    logic             w_under;
    logic [EXP_W-1:0] w_lz_ext;
    logic [COUNT-1:0] w_sh;
    logic [WIDTH-1:0] w_mant;
    logic [EXP_W-1:0] w_exp;

    assign w_adv2     = r_s1_v & (~r_s2_v | bus.out_ready);
    assign w_in_ready = ~r_s1_v | w_adv2;
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_pop      = r_s2_v & bus.out_ready;

    // When the exponent is smaller than the zero count it is below WIDTH, so it fits the shifter.
    assign w_zero   = ~r_s1_nz;
    assign w_lz_ext = EXP_W'(r_s1_lz);
    assign w_under  = r_s1_exp < w_lz_ext;
    assign w_sh     = w_under ? r_s1_exp[COUNT-1:0] : r_s1_lz;
    assign w_mant   = w_zero ? '0 : (r_s1_data << w_sh);
    assign w_exp    = w_zero ? '0 : (r_s1_exp - EXP_W'(w_sh));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_data <= '0;
            r_s1_lz   <= '0;
            r_s1_nz   <= 1'b0;
            r_s1_exp  <= '0;
        end else if (w_accept) begin
            r_s1_v    <= 1'b1;
            r_s1_data <= bus.in_data;
            r_s1_lz   <= bus.in_lz;
            r_s1_nz   <= bus.in_nz;
            r_s1_exp  <= bus.in_exp;
        end else if (w_adv2) begin
            r_s1_v    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_v  <= 1'b0;
            r_mant  <= '0;
            r_exp   <= '0;
            r_zero  <= 1'b0;
            r_uflow <= 1'b0;
        end else if (w_adv2) begin
            r_s2_v  <= 1'b1;
            r_mant  <= w_mant;
            r_exp   <= w_exp;
            r_zero  <= w_zero;
            r_uflow <= ~w_zero & w_under;
        end else if (bus.out_ready) begin
            r_s2_v  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_uflow_cnt <= '0;
        end else if (w_pop && r_uflow && (r_uflow_cnt != 16'hFFFF)) begin
            r_uflow_cnt <= r_uflow_cnt + 16'd1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_v;
    assign bus.out_mant  = r_mant;
    assign bus.out_exp   = r_exp;
    assign bus.out_zero  = r_zero;
    assign bus.out_uflow = r_uflow;
    assign bus.uflow_cnt = r_uflow_cnt;

endmodule

// File: tb/tb_lzc_normalizer.sv
// Randomised and directed bench for lzc_normalizer against a queue-based reference model.
module tb_lzc_normalizer;

    localparam int WIDTH = 16;
    localparam int COUNT = 4;
    localparam int EXP_W = 8;

    typedef struct {
        logic [15:0] mant;
        logic [7:0]  exp;
        logic        zero;
        logic        uflow;
    } beat_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   modelCnt;
    beat_t q[$];

    lzc_normalizer_if #(.WIDTH(WIDTH), .COUNT(COUNT), .EXP_W(EXP_W)) bus ();

    lzc_normalizer #(.WIDTH(WIDTH), .COUNT(COUNT), .EXP_W(EXP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic int countLz(input logic [15:0] d);
        int n = 0;
        for (int i = 15; i >= 0; i--) begin
            if (d[i]) break;
            n++;
        end
        return n;
    endfunction

    // Shift left as far as the exponent allows, using plain arithmetic on wide integers.
    function automatic beat_t refModel(input logic [15:0] d, input int lz, input logic nz, input int e);
        beat_t b;
        longint sh;
        if (!nz) begin
            b.mant = 16'h0; b.exp = 8'h0; b.zero = 1'b1; b.uflow = 1'b0;
        end else begin
            sh      = (e >= lz) ? lz : e;
            b.mant  = 16'((longint'(d) * (longint'(1) << sh)) % 65536);
            b.exp   = 8'(e - sh);
            b.zero  = 1'b0;
            b.uflow = (e < lz);
        end
        return b;
    endfunction

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] lz, input logic nz, input logic [7:0] e);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_lz    = lz;
        bus.in_nz    = nz;
        bus.in_exp   = e;
    endtask

    // One clock: observe on the falling edge, update the model, then move past the rising edge.
    task automatic stepCycle();
        beat_t e;
        @(negedge clk);
        checkOutput("in_ready", bus.in_ready, (q.size() < 2) || bus.out_ready);
        if (q.size() == 0) checkOutput("idle_valid", bus.out_valid, 0);
        if (q.size() == 2) checkOutput("full_valid", bus.out_valid, 1);
        checkOutput("uflow_cnt", bus.uflow_cnt, modelCnt);
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                checkOutput("spurious_beat", bus.out_valid, 0);
            end else begin
                e = q.pop_front();
                checkOutput("mant", bus.out_mant, e.mant);
                checkOutput("exp", bus.out_exp, e.exp);
                checkOutput("zero", bus.out_zero, e.zero);
                checkOutput("uflow", bus.out_uflow, e.uflow);
                if (e.uflow && modelCnt < 65535) modelCnt++;
            end
        end
        if (bus.in_valid && bus.in_ready)
            q.push_back(refModel(bus.in_data, int'(bus.in_lz), bus.in_nz, int'(bus.in_exp)));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) stepCycle();
        checkOutput("drain_timeout", q.size(), 0);
    endtask

    task automatic runDirected(input string tag, input logic [15:0] d, input logic [3:0] lz, input logic nz,
                               input logic [7:0] e, input logic [15:0] emant, input logic [7:0] eexp,
                               input logic ezero, input logic euf);
        int cntBefore;
        drain();
        cntBefore = modelCnt;
        applyStimulus(d, lz, nz, e);
        stepCycle();
        bus.in_valid = 1'b0;
        checkOutput({tag, "_lat1"}, bus.out_valid, 0);
        stepCycle();
        checkOutput({tag, "_valid"}, bus.out_valid, 1);
        checkOutput({tag, "_mant"}, bus.out_mant, emant);
        checkOutput({tag, "_exp"}, bus.out_exp, eexp);
        checkOutput({tag, "_zero"}, bus.out_zero, ezero);
        checkOutput({tag, "_uflow"}, bus.out_uflow, euf);
        stepCycle();
        checkOutput({tag, "_cnt"}, bus.uflow_cnt, cntBefore + int'(euf));
    endtask

    initial begin
        logic [15:0] d;
        int sent;
        checks   = 0;
        failures = 0;
        modelCnt = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_lz = '0; bus.in_nz = 1'b0; bus.in_exp = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_in_ready", bus.in_ready, 1);
        checkOutput("rst_mant", bus.out_mant, 0);
        checkOutput("rst_exp", bus.out_exp, 0);
        checkOutput("rst_cnt", bus.uflow_cnt, 0);
        rst = 1'b0;

        runDirected("normal", 16'h0010, 4'd11, 1'b1, 8'd20, 16'h8000, 8'd9, 1'b0, 1'b0);
        runDirected("zero", 16'h0000, 4'd15, 1'b0, 8'd77, 16'h0000, 8'd0, 1'b1, 1'b0);
        runDirected("uflow", 16'h0001, 4'd15, 1'b1, 8'd5, 16'h0020, 8'd0, 1'b0, 1'b1);
        runDirected("norm0", 16'h8000, 4'd0, 1'b1, 8'd0, 16'h8000, 8'd0, 1'b0, 1'b0);

        // Backpressure: six beats offered back-to-back, consumer stalls during cycles 3-5.
        drain();
        sent = 0;
        for (int cyc = 0; cyc < 40 && sent < 6; cyc++) begin
            d = 16'($urandom_range(1, 65535));
            if (!bus.in_valid || bus.in_ready === 1'b1) applyStimulus(d, 4'(countLz(d)), 1'b1, 8'($urandom_range(0, 20)));
            bus.out_ready = !(cyc >= 2 && cyc <= 4);
            #1;
            if (bus.in_valid && bus.in_ready) sent++;
            stepCycle();
        end
        checkOutput("bp_sent", sent, 6);
        drain();

        // Randomised traffic with random backpressure.
        for (int cyc = 0; cyc < 500; cyc++) begin
            if ($urandom_range(0, 7) == 0) begin
                applyStimulus(16'h0, 4'($urandom_range(0, 15)), 1'b0, 8'($urandom));
            end else begin
                d = 16'($urandom_range(1, 65535)) >> $urandom_range(0, 15);
                if (d == 16'h0) d = 16'h1;
                applyStimulus(d, 4'(countLz(d)), 1'b1, 8'($urandom_range(0, 24)));
            end
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            stepCycle();
        end
        drain();

        // Reset with two beats in flight: both must vanish.
        bus.out_ready = 1'b0;
        applyStimulus(16'h0100, 4'd7, 1'b1, 8'd30);
        stepCycle();
        applyStimulus(16'h0003, 4'd14, 1'b1, 8'd2);
        stepCycle();
        bus.in_valid = 1'b0;
        checkOutput("mid_full", bus.out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", bus.out_valid, 0);
        checkOutput("mid_rst_ready", bus.in_ready, 1);
        checkOutput("mid_rst_cnt", bus.uflow_cnt, 0);
        q.delete();
        modelCnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        checkOutput("post_rst_ready", bus.in_ready, 1);
        repeat (6) stepCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
